// File: rtl/music_box_pkg.sv
// Shared constants, state encoding and song ROM field layout for the music box sequencer.
package music_box_pkg;

    localparam int unsigned NOTE_W = 8;
    localparam int unsigned DUR_W  = 8;

    localparam logic [NOTE_W-1:0] NOTE_REST = 8'h00;
    localparam logic [NOTE_W-1:0] NOTE_END  = 8'hFF;
    localparam logic [NOTE_W-1:0] NOTE_MIN  = 8'h01;
    localparam logic [NOTE_W-1:0] NOTE_MAX  = 8'h24;

    localparam int unsigned NOTE_MSB = 15;
    localparam int unsigned NOTE_LSB = 8;
    localparam int unsigned DUR_MSB  = 7;
    localparam int unsigned DUR_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_PLAY,
        ST_GAP
    } state_t;

endpackage

// File: rtl/note_period_lut.sv
// Note code to square-wave period lookup; table built at elaboration from CLK_HZ.
module note_period_lut
    import music_box_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic [NOTE_W-1:0] code,
    output logic [31:0]       period_c
);

    localparam int unsigned NUM_NOTES = 36;
    localparam int unsigned MIDI_BASE = 48;

    // Equal temperament around A4 = 440 Hz, rounded to the nearest clock cycle.
    function automatic logic [31:0] note_period(input int unsigned midi);
        real freq;
        freq = 440.0 * (2.0 ** ((real'(midi) - 69.0) / 12.0));
        return 32'($rtoi(real'(CLK_HZ) / freq + 0.5));
    endfunction

    logic [31:0] table_w [NUM_NOTES];

    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_tbl
        localparam logic [31:0] PERIOD = note_period(MIDI_BASE + i);
        assign table_w[i] = PERIOD;
    end

    always_comb begin
        period_c = '0;
        if ((code >= NOTE_MIN) && (code <= NOTE_MAX)) begin
            period_c = table_w[6'(code - NOTE_MIN)];
        end
    end

endmodule

// File: rtl/music_box_sequencer.sv
// Walks a song ROM of {note, duration} entries and drives the square-wave voice
// with a note period and a gated play_note, followed by a fixed articulation gap.
module music_box_sequencer
    import music_box_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned GAP_TICKS = 2,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [31:0]       hz,
    output logic              play_note,
    output logic              busy,
    output logic              done
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);

    state_t             state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [DUR_W-1:0]   dur_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NOTE_W-1:0]  note;
    logic [DUR_W-1:0]   dur;
    logic [31:0]        lut_period;
    logic               is_note;
    logic               tick;

    assign note    = rom_data[NOTE_MSB:NOTE_LSB];
    assign dur     = rom_data[DUR_MSB:DUR_LSB];
    assign is_note = (note >= NOTE_MIN) && (note <= NOTE_MAX);
    assign tick    = (tick_cnt == TICK_LAST);

    note_period_lut #(
        .CLK_HZ (CLK_HZ)
    ) u_lut (
        .code     (note),
        .period_c (lut_period)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rom_addr  <= '0;
            hz        <= '0;
            play_note <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tick_cnt  <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            // Stop wins over everything, including a held start.
            if (stop) begin
                state     <= ST_IDLE;
                rom_addr  <= '0;
                hz        <= '0;
                play_note <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        if (note == NOTE_END) begin
                            rom_addr <= '0;
                            if (loop_en) begin
                                state <= ST_FETCH;
                            end else begin
                                state <= ST_IDLE;
                                hz    <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (dur == '0) begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= ST_FETCH;
                        end else begin
                            if (is_note) begin
                                hz <= lut_period;
                            end
                            play_note <= is_note;
                            dur_cnt   <= dur;
                            tick_cnt  <= '0;
                            state     <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                        if (tick) begin
                            if (dur_cnt == DUR_W'(1)) begin
                                play_note <= 1'b0;
                                gap_cnt   <= '0;
                                state     <= ST_GAP;
                            end else begin
                                dur_cnt <= dur_cnt - DUR_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                        if (tick) begin
                            if (gap_cnt == GAP_LAST) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= ST_FETCH;
                            end else begin
                                gap_cnt <= gap_cnt + GAP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_box_sequencer.sv
// Scoreboard bench: scenarios queue expected output changes by cycle; a monitor compares them.
module tb_music_box_sequencer;

    localparam int unsigned CLK_HZ    = 50000000;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned GAP_TICKS = 2;
    localparam int unsigned ADDR_W    = 8;

    localparam logic [31:0] HZ_A4 = 32'd113636;
    localparam logic [31:0] HZ_C4 = 32'd191113;
    localparam logic [31:0] HZ_B4 = 32'd101238;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [31:0]       hz;
    logic              play_note;
    logic              busy;
    logic              done;

    logic [15:0] rom [256];

    music_box_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .TICK_DIV  (TICK_DIV),
        .GAP_TICKS (GAP_TICKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .hz        (hz),
        .play_note (play_note),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic        busy;
        logic        play;
        logic        done;
        logic [31:0] hz;
    } ev_t;

    typedef struct {
        int unsigned       cyc;
        logic [ADDR_W-1:0] addr;
        logic              busy;
        logic              play;
        logic              done;
        logic [31:0]       hz;
    } probe_t;

    ev_t    exp_q[$];
    probe_t pr_q[$];

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  end_req = 1'b0;

    logic [34:0] mon_cur;
    logic [34:0] mon_prev;
    ev_t         mon_e;
    probe_t      mon_p;

    // Monitor: every change on the voice-facing outputs must match the next queued event.
    always @(negedge clock) begin
        mon_cur = {busy, play_note, done, hz};
        if (!mon_en) begin
            mon_prev = mon_cur;
        end else begin
            if (mon_cur !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got busy=%0b play=%0b done=%0b hz=%0d, required no change",
                             cyc, busy, play_note, done, hz);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_cur !== {mon_e.busy, mon_e.play, mon_e.done, mon_e.hz}) begin
                        errors++;
                        $display("FAIL event got cyc=%0d busy=%0b play=%0b done=%0b hz=%0d, required cyc=%0d busy=%0b play=%0b done=%0b hz=%0d",
                                 cyc, busy, play_note, done, hz,
                                 mon_e.cyc, mon_e.busy, mon_e.play, mon_e.done, mon_e.hz);
                    end
                end
                mon_prev = mon_cur;
            end
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_event at cyc=%0d, required busy=%0b play=%0b done=%0b hz=%0d",
                         mon_e.cyc, mon_e.busy, mon_e.play, mon_e.done, mon_e.hz);
            end
            if (pr_q.size() != 0 && pr_q[0].cyc <= cyc) begin
                mon_p = pr_q.pop_front();
                checks++;
                if (mon_p.cyc != cyc || rom_addr !== mon_p.addr || busy !== mon_p.busy ||
                    play_note !== mon_p.play || done !== mon_p.done || hz !== mon_p.hz) begin
                    errors++;
                    $display("FAIL probe got cyc=%0d addr=%0d busy=%0b play=%0b done=%0b hz=%0d, required cyc=%0d addr=%0d busy=%0b play=%0b done=%0b hz=%0d",
                             cyc, rom_addr, busy, play_note, done, hz,
                             mon_p.cyc, mon_p.addr, mon_p.busy, mon_p.play, mon_p.done, mon_p.hz);
                end
            end
            if (end_req) begin
                checks++;
                if (exp_q.size() != 0 || pr_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover got events=%0d probes=%0d, required 0 and 0", exp_q.size(), pr_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    task automatic ev(input int unsigned c, input logic b, input logic p, input logic d, input logic [31:0] h);
        exp_q.push_back('{c, b, p, d, h});
    endtask

    task automatic probe(input int unsigned c, input logic [ADDR_W-1:0] a, input logic b, input logic p,
                         input logic d, input logic [31:0] h);
        pr_q.push_back('{c, a, b, p, d, h});
    endtask

    // Raise start at a falling edge; n is the rising edge that samples it.
    task automatic start_at(output int unsigned n);
        start = 1'b1;
        n = cyc + 1;
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (exp_q.size() != 0 || pr_q.size() != 0); i++) @(negedge clock);
        repeat (3) @(negedge clock);
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFF00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d, required bench completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        clear_rom();
        repeat (3) @(negedge clock);
        mon_en = 1'b1;
        probe(cyc + 1, '0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // A4 for 3 ticks then end marker
        rom[0] = 16'h1603; rom[1] = 16'hFF00; loop_en = 1'b0;
        start_at(n);
        ev(n,      1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 2,  1'b1, 1'b1, 1'b0, HZ_A4);
        ev(n + 14, 1'b1, 1'b0, 1'b0, HZ_A4);
        ev(n + 24, 1'b0, 1'b0, 1'b1, 32'd0);
        ev(n + 25, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 24, '0, 1'b0, 1'b0, 1'b1, 32'd0);
        @(negedge clock);
        start = 1'b0;
        drain(100);

        // C4, rest, end marker with looping, then stop in the second gap
        clear_rom();
        rom[0] = 16'h0D02; rom[1] = 16'h0001; rom[2] = 16'hFF00; loop_en = 1'b1;
        start_at(n);
        ev(n,      1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 2,  1'b1, 1'b1, 1'b0, HZ_C4);
        ev(n + 10, 1'b1, 1'b0, 1'b0, HZ_C4);
        ev(n + 36, 1'b1, 1'b1, 1'b0, HZ_C4);
        ev(n + 44, 1'b1, 1'b0, 1'b0, HZ_C4);
        ev(n + 50, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 20, 8'd1, 1'b1, 1'b0, 1'b0, HZ_C4);
        probe(n + 34, 8'd0, 1'b1, 1'b0, 1'b0, HZ_C4);
        @(negedge clock);
        start = 1'b0;
        wait_cyc(n + 49);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        loop_en = 1'b0;
        drain(100);

        // Zero-duration entry is skipped, then B4 for one tick
        clear_rom();
        rom[0] = 16'h1600; rom[1] = 16'h1801; rom[2] = 16'hFF00;
        start_at(n);
        ev(n,      1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 4,  1'b1, 1'b1, 1'b0, HZ_B4);
        ev(n + 8,  1'b1, 1'b0, 1'b0, HZ_B4);
        ev(n + 18, 1'b0, 1'b0, 1'b1, 32'd0);
        ev(n + 19, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 2, 8'd1, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        start = 1'b0;
        drain(100);

        // Stop five cycles into a 3-tick note while start stays high
        clear_rom();
        rom[0] = 16'h1603; rom[1] = 16'hFF00;
        start_at(n);
        ev(n,     1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 2, 1'b1, 1'b1, 1'b0, HZ_A4);
        ev(n + 7, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 7,  '0, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 10, '0, 1'b0, 1'b0, 1'b0, 32'd0);
        wait_cyc(n + 6);
        stop = 1'b1;
        wait_cyc(n + 10);
        start = 1'b0;
        stop  = 1'b0;
        drain(100);

        // Invalid note code plays as a rest and keeps the previous period
        clear_rom();
        rom[0] = 16'h1601; rom[1] = 16'h3003; rom[2] = 16'hFF00;
        start_at(n);
        ev(n,      1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 2,  1'b1, 1'b1, 1'b0, HZ_A4);
        ev(n + 6,  1'b1, 1'b0, 1'b0, HZ_A4);
        ev(n + 38, 1'b0, 1'b0, 1'b1, 32'd0);
        ev(n + 39, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 22, 8'd1, 1'b1, 1'b0, 1'b0, HZ_A4);
        @(negedge clock);
        start = 1'b0;
        drain(100);

        // Reset mid-note, then a fresh start replays address 0
        clear_rom();
        rom[0] = 16'h1603; rom[1] = 16'hFF00;
        start_at(n);
        ev(n,     1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 2, 1'b1, 1'b1, 1'b0, HZ_A4);
        ev(n + 5, 1'b0, 1'b0, 1'b0, 32'd0);
        probe(n + 5, '0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        start = 1'b0;
        wait_cyc(n + 4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        start_at(n);
        ev(n,      1'b1, 1'b0, 1'b0, 32'd0);
        ev(n + 2,  1'b1, 1'b1, 1'b0, HZ_A4);
        ev(n + 14, 1'b1, 1'b0, 1'b0, HZ_A4);
        ev(n + 24, 1'b0, 1'b0, 1'b1, 32'd0);
        ev(n + 25, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clock);
        start = 1'b0;
        drain(100);

        end_req = 1'b1;
    end

endmodule

// File: doc/music_box_sequencer.md
Name: music_box_sequencer

Overview:
- Upstream stage of the square-wave voice. It walks a song ROM of {note, duration} entries and converts each note code to a period in clock cycles on `hz`.
- It holds `play_note` high for the note's duration, then low for a fixed articulation gap.
- It supports start, stop and loop, and is the only driver of the voice's `play_note` and `hz` inputs.

Parameters:
- CLK_HZ, 50000000, system clock frequency; used to build the period table.
- TICK_DIV, 500000, clock cycles per tempo tick (10 ms at 50 MHz).
- GAP_TICKS, 2, ticks of silence after every sounded note or rest.
- ADDR_W, 8, song ROM address width.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level, sampled each edge; begins playback from address 0 when IDLE.
- stop  in  1  level; aborts playback; has priority over start.
- loop_en  in  1  when 1, the end marker restarts at address 0.
- rom_addr  out  ADDR_W  song ROM address; synchronous ROM, 1-cycle read latency.
- rom_data  in  16  [15:8] note code, [7:0] duration in ticks.
- hz  out  32  note period in clock cycles, unsigned.
- play_note  out  1  high while a note sounds.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the end marker is reached with loop_en=0.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE.
  - rom_addr=0, hz=0, play_note=0, busy=0, done=0.
  - Tick counter cleared.
- Note codes:
  - 0x00 = rest.
  - 0x01..0x24 = MIDI 48..83 (C3..B5). Period = round(CLK_HZ / (440 * 2^((midi-69)/12))).
  - 0xFF = end marker.
  - Any other code is treated as a rest.
- States: IDLE, FETCH, DECODE, PLAY, GAP.
- IDLE:
  - Outputs low and rom_addr=0.
  - start=1 and stop=0 → FETCH.
- FETCH: one cycle, the ROM registers rom_addr → DECODE.
- DECODE: rom_data is valid; one cycle.
  - End marker, loop_en=1 → rom_addr=0, FETCH.
  - End marker, loop_en=0 → done=1 for one cycle, IDLE.
  - Duration 0 → entry skipped, rom_addr+1, FETCH.
  - Otherwise → load hz (hz left unchanged for rests) and the duration, clear the tick counter → PLAY.
  - play_note is set registered, so it is high the cycle PLAY is entered for note codes, and stays 0 for rests.
- PLAY:
  - play_note/hz are held.
  - The tick counter pulses every TICK_DIV cycles.
  - After `duration` ticks (exactly duration*TICK_DIV cycles in PLAY), play_note goes to 0 → GAP.
- GAP:
  - play_note=0, hz held.
  - After GAP_TICKS ticks, rom_addr+1 → FETCH.
  - rom_addr wraps from 2^ADDR_W-1 to 0 with no end condition.
- Latency:
  - start sampled at edge N → FETCH after N, DECODE after N+1.
  - play_note high after edge N+2.
- stop=1 in any non-IDLE state:
  - Next edge: IDLE, play_note=0, rom_addr=0, no done pulse.
- start while busy: ignored.
- Reset mid-note: same as the reset values above; the next start replays from address 0.
- Width and arithmetic rules:
  - Tick counter width: clog2(TICK_DIV).
  - Duration counter: 8 bits. Gap counter: clog2(GAP_TICKS+1).
  - No arithmetic on hz; it is a table lookup, zero-extended to 32 bits.

Decomposition:
- Shared package `music_box_pkg`:
  - NOTE_REST=8'h00, NOTE_END=8'hFF, NOTE_MIN=8'h01, NOTE_MAX=8'h24.
  - The state enum.
  - ROM field positions (NOTE_MSB=15, NOTE_LSB=8, DUR_MSB=7, DUR_LSB=0).
- Sub-module `note_period_lut`: combinational, input 8-bit code, output 32-bit period.
  - Entries computed from CLK_HZ.
  - Returns 0 for codes outside 0x01..0x24.
  - Instantiated once.

Test Plan (TICK_DIV=4, GAP_TICKS=2, CLK_HZ=50000000):
- ROM[0]=0x1603, ROM[1]=0xFF00, loop_en=0; pulse start.
  - → play_note high after edge N+2 for 12 cycles with hz=113636 (A4).
  - → then low 8 cycles, then done pulses once; busy falls the same cycle.
- ROM[0]=0x0D02, ROM[1]=0x0001, ROM[2]=0xFF00, loop_en=1.
  - → hz=191113 (C4) high 8 cycles, gap 8.
  - → rest: play_note low 4+8 cycles.
  - → replays from address 0; done never pulses.
- ROM[0]=0x1600 (duration 0), ROM[1]=0x1801.
  - → entry 0 skipped with no play_note pulse.
  - → hz=101238 (B4), high 4 cycles.
- stop asserted 5 cycles into a 3-tick note, with start held high.
  - → play_note=0 and IDLE on the next edge; rom_addr=0; no done pulse; busy=0.
- ROM[0]=0x3003 (invalid code) → treated as a rest: play_note stays 0 for 12+8 cycles, hz unchanged.
- reset during PLAY → all outputs 0 next edge; a subsequent start replays ROM[0] with the same latency of 2 edges.
